// File: rtl/zx_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zx_mem_pkg                                                                 |
// | Shared types and default widths for the ZX RAM arbiter slice.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package zx_mem_pkg;

  localparam int ZX_ADDR_W = 16;
  localparam int ZX_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/zx_ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zx_ram_arbiter_if                                                          |
// | Video, CPU and RAM-side signal bundle; slave = arbiter, master = clients.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface zx_ram_arbiter_if
  import zx_mem_pkg::*;
#(
  parameter int ADDR_W = ZX_ADDR_W,
  parameter int DATA_W = ZX_DATA_W
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_wait;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    output vid_data, vid_ack, cpu_dout, cpu_ack, cpu_wait, ram_we, ram_addr, ram_din
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_dout,
    input  vid_data, vid_ack, cpu_dout, cpu_ack, cpu_wait, ram_we, ram_addr, ram_din
  );

endinterface
`default_nettype wire

// File: rtl/zx_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zx_rr_pick                                                                 |
// | Two-way round-robin winner: video by default, CPU if video won last time.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module zx_rr_pick
  import zx_mem_pkg::*;
(
  input  wire         vid_elig,
  input  wire         cpu_elig,
  input  wire owner_e last_grant,
  output logic        grant_valid,
  output owner_e      grant
);

  always_comb begin
    grant_valid = vid_elig | cpu_elig;
    grant       = OWN_VID;
    if (cpu_elig && (!vid_elig || (last_grant == OWN_VID))) begin
      grant = OWN_CPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/zx_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zx_ram_arbiter                                                             |
// | Shares one single-port RAM between video fetch and CPU, 3 cycles/access.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module zx_ram_arbiter
  import zx_mem_pkg::*;
#(
  parameter int ADDR_W = ZX_ADDR_W,
  parameter int DATA_W = ZX_DATA_W
)
(
  input wire              clk_a,
  input wire              reset,
  zx_ram_arbiter_if.slave bus
);

  arb_state_e        r_state,    w_state_nxt;
  owner_e            r_owner,    w_owner_nxt;
  logic              r_acc_we,   w_acc_we_nxt;
  logic              r_ram_we,   w_ram_we_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0] r_ram_din,  w_ram_din_nxt;
  logic              r_vid_ack,  w_vid_ack_nxt;
  logic              r_cpu_ack,  w_cpu_ack_nxt;
  logic [DATA_W-1:0] r_vid_data, w_vid_data_nxt;
  logic [DATA_W-1:0] r_cpu_dout, w_cpu_dout_nxt;

  logic              w_vid_elig;
  logic              w_cpu_elig;
  logic              w_grant_valid;
  owner_e            w_grant;

  // A held request is stale during its own ack cycle.
  assign w_vid_elig = bus.vid_req & ~r_vid_ack;
  assign w_cpu_elig = bus.cpu_req & ~r_cpu_ack;

  // r_owner also serves as the last-grant memory for alternation.
  zx_rr_pick u_rr_pick (
    .vid_elig    (w_vid_elig),
    .cpu_elig    (w_cpu_elig),
    .last_grant  (r_owner),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_acc_we_nxt   = r_acc_we;
    w_ram_we_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_vid_ack_nxt  = 1'b0;
    w_cpu_ack_nxt  = 1'b0;
    w_vid_data_nxt = r_vid_data;
    w_cpu_dout_nxt = r_cpu_dout;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = ST_ISSUE;
          w_owner_nxt = w_grant;
          if (w_grant == OWN_CPU) begin
            w_ram_addr_nxt = bus.cpu_addr;
            w_ram_din_nxt  = bus.cpu_din;
            w_ram_we_nxt   = bus.cpu_we;
            w_acc_we_nxt   = bus.cpu_we;
          end else begin
            w_ram_addr_nxt = bus.vid_addr;
            w_acc_we_nxt   = 1'b0;
          end
        end
      end

      ST_ISSUE: begin
        w_state_nxt = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        w_state_nxt = ST_IDLE;
        if (r_owner == OWN_CPU) begin
          w_cpu_ack_nxt = 1'b1;
          if (!r_acc_we) begin
            w_cpu_dout_nxt = bus.ram_dout;
          end
        end else begin
          w_vid_ack_nxt  = 1'b1;
          w_vid_data_nxt = bus.ram_dout;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_CPU;
      r_acc_we   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_vid_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_vid_data <= '0;
      r_cpu_dout <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_acc_we   <= w_acc_we_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_vid_ack  <= w_vid_ack_nxt;
      r_cpu_ack  <= w_cpu_ack_nxt;
      r_vid_data <= w_vid_data_nxt;
      r_cpu_dout <= w_cpu_dout_nxt;
    end
  end

  // Masking with reset keeps a write aborted in ISSUE from reaching the RAM.
  assign bus.ram_we   = r_ram_we & ~reset;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.vid_ack  = r_vid_ack;
  assign bus.vid_data = r_vid_data;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.cpu_dout = r_cpu_dout;
  assign bus.cpu_wait = bus.cpu_req & ~r_cpu_ack;

endmodule
`default_nettype wire
